// File: rtl/ram_requester.sv
// Initiator-side controller for the change-triggered word RAM: takes single
// read/write requests, drives the RAM lines and returns a one-cycle response.
module ram_requester #(
   parameter int RAM_SIZE = 1024,
   parameter int TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] ram_data,
   output logic [31:0] ram_addr,
   output logic        ram_wr,
   input  logic        ram_response,
   input  logic [31:0] ram_out
);

   localparam int          CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [31:0] RAM_SIZE_W = 32'(RAM_SIZE);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      ram_data_q, ram_data_d;
   logic [31:0]      ram_addr_q, ram_addr_d;
   logic             ram_wr_q, ram_wr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             seen_low_q, seen_low_d;
   logic             same_q, same_d;
   logic             sync_hi_q, sync_hi_d;

   logic             addr_ok;
   logic [31:0]      next_data;
   logic             new_same;
   logic             done;
   logic             cnt_sat;

   // A read keeps the previously driven data so only addr/wr can change.
   always_comb begin
      addr_ok   = (req_addr < RAM_SIZE_W);
      next_data = req_wr ? req_wdata : ram_data_q;
      new_same  = (req_wr == ram_wr_q) && (req_addr == ram_addr_q) &&
                  (next_data == ram_data_q);
      cnt_sat   = (cnt_q == CNT_MAX);
      // An identical repeat never pulls response low, so same stands in for seen_low.
      done      = ram_response && (cnt_q != '0) && (seen_low_q || same_q);
   end

   always_comb begin
      state_d     = state_q;
      ram_data_d  = ram_data_q;
      ram_addr_d  = ram_addr_q;
      ram_wr_d    = ram_wr_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;
      seen_low_d  = seen_low_q;
      same_d      = same_q;
      sync_hi_d   = sync_hi_q;
      req_ready   = 1'b0;

      case (state_q)
         ST_SYNC: begin
            // The RAM has no reset; wait until it has settled on the driven zeros.
            if (ram_response) begin
               if (sync_hi_q) begin
                  sync_hi_d = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  sync_hi_d = 1'b1;
               end
            end else begin
               sync_hi_d = 1'b0;
            end
         end

         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (!addr_ok) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  ram_addr_d = req_addr;
                  ram_wr_d   = req_wr;
                  ram_data_d = next_data;
                  same_d     = new_same;
                  cnt_d      = '0;
                  seen_low_d = 1'b0;
                  state_d    = ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            if (!cnt_sat) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (!ram_response) begin
               seen_low_d = 1'b1;
            end
            if (done) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = ram_wr_q ? 32'd0 : ram_out;
               state_d     = ST_IDLE;
            end else if (cnt_sat) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_SYNC;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SYNC;
         ram_data_q  <= '0;
         ram_addr_q  <= '0;
         ram_wr_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
         seen_low_q  <= 1'b0;
         same_q      <= 1'b0;
         sync_hi_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_data_q  <= ram_data_d;
         ram_addr_q  <= ram_addr_d;
         ram_wr_q    <= ram_wr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
         seen_low_q  <= seen_low_d;
         same_q      <= same_d;
         sync_hi_q   <= sync_hi_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign ram_data  = ram_data_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_ram_requester.sv
// Directed bench for ram_requester with a behavioural change-triggered RAM
// and a response scoreboard.
module tb_ram_requester;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] ram_data;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic        ram_response;
   logic [31:0] ram_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb[$];

   ram_requester #(.RAM_SIZE(1024), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_data(ram_data), .ram_addr(ram_addr), .ram_wr(ram_wr),
      .ram_response(ram_response), .ram_out(ram_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural RAM: a change of inputs at a negedge drops response,
   // stable inputs execute the operation and raise it.
   logic [31:0] mem [0:1023];
   logic [31:0] last_data  = '0;
   logic [31:0] last_addr  = '0;
   logic        last_wr    = 1'b0;
   logic        model_resp = 1'b1;
   logic [31:0] model_out  = '0;
   logic        stub_low   = 1'b0;

   always @(negedge clk) begin
      if ({ram_wr, ram_addr, ram_data} !== {last_wr, last_addr, last_data}) begin
         model_resp <= 1'b0;
         last_wr    <= ram_wr;
         last_addr  <= ram_addr;
         last_data  <= ram_data;
      end else begin
         if (ram_wr) mem[ram_addr[9:0]] <= ram_data;
         model_out  <= ram_wr ? ram_data : mem[ram_addr[9:0]];
         model_resp <= 1'b1;
      end
   end

   assign ram_response = stub_low ? 1'b0 : model_resp;
   assign ram_out      = model_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits for req_ready; rsp_valid must stay low meanwhile.
   task automatic wait_ready(input string tag, input int limit);
      int n = 0;
      logic rsp_seen = 1'b0;
      while (!req_ready && n < limit + 2) begin
         @(posedge clk); #1;
         n++;
         if (rsp_valid) rsp_seen = 1'b1;
      end
      check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_in_time"}, {31'd0, (n <= limit)}, 32'd1);
      check({tag, "_no_rsp"}, {31'd0, rsp_seen}, 32'd0);
   endtask

   // Latency counts posedges after the edge that samples req_valid.
   task automatic issue(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, output int lows);
      exp_t e;
      exp_t got;
      int   t0;
      int   waited = 0;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk); #1;
      t0 = cyc;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = exp_lat;
      sb.push_back(e);
      req_valid = 1'b0;
      lows = ram_response ? 0 : 1;
      while (!rsp_valid && waited < 40) begin
         @(posedge clk); #1;
         waited++;
         if (!ram_response) lows++;
      end
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      if (rsp_valid && sb.size() > 0) begin
         got = sb.pop_front();
         check({tag, "_rdata"}, rsp_rdata, got.rdata);
         check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, got.err});
         check({tag, "_latency"}, 32'(cyc - t0), 32'(got.lat));
      end
   endtask

   initial begin
      int lows;
      logic [31:0] sv_addr, sv_data;
      logic        sv_wr;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_ram_addr", ram_addr, 32'd0);
      check("rst_ram_data", ram_data, 32'd0);
      check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
      rst = 1'b0;
      wait_ready("sync1", 3);

      // Write then read back
      issue("wr5", 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0, 2, lows);
      check("wr5_low_cycles", 32'(lows), 32'd1);
      issue("rd5", 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, lows);
      check("rd5_low_cycles", 32'(lows), 32'd1);

      // Identical repeats complete without a response low pulse
      issue("rd5_rep1", 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, lows);
      check("rd5_rep1_lows", 32'(lows), 32'd0);
      issue("rd5_rep2", 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, lows);
      check("rd5_rep2_lows", 32'(lows), 32'd0);

      // Highest valid address
      issue("wr1023", 1'b1, 32'd1023, 32'h0000_0001, 32'd0, 1'b0, 2, lows);
      issue("rd1023", 1'b0, 32'd1023, 32'h0, 32'h0000_0001, 1'b0, 2, lows);
      issue("rd5_again", 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, lows);

      // Out-of-range address leaves the RAM lines untouched
      sv_addr = ram_addr;
      sv_data = ram_data;
      sv_wr   = ram_wr;
      issue("oob1024", 1'b1, 32'd1024, 32'h1234_5678, 32'd0, 1'b1, 0, lows);
      check("oob_ram_addr", ram_addr, sv_addr);
      check("oob_ram_data", ram_data, sv_data);
      check("oob_ram_wr", {31'd0, ram_wr}, {31'd0, sv_wr});
      check("oob_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      check("oob_pulse_one", {31'd0, rsp_valid}, 32'd0);
      check("oob_err_hold", {31'd0, rsp_err}, 32'd1);

      // RAM never answers: timeout after TIMEOUT counted WAIT cycles
      stub_low = 1'b1;
      issue("tmo", 1'b0, 32'd7, 32'h0, 32'd0, 1'b1, 17, lows);
      @(posedge clk); #1;
      check("tmo_ready_after", {31'd0, req_ready}, 32'd1);
      check("tmo_pulse_one", {31'd0, rsp_valid}, 32'd0);
      stub_low = 1'b0;
      @(posedge clk); #1;

      // Reset one cycle into WAIT abandons the request
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 32'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid_rst_ram_addr", ram_addr, 32'd0);
      check("mid_rst_ram_data", ram_data, 32'd0);
      check("mid_rst_ram_wr", {31'd0, ram_wr}, 32'd0);
      check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_ready("sync2", 6);
      issue("rd5_post_rst", 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, lows);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
